// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between the instruction-refill port and the data port.
// Data has priority; instruction refills are guaranteed a grant after MAX_DSTREAK data grants.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | bus free; the only state in which requests are sampled
// IBUSY | instruction refill in flight on the bus
// DBUSY | data read or write in flight on the bus
module mem_port_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ireq,
    input  logic [31:0] i_iaddr,
    output logic        o_ivd,
    output logic [31:0] o_idata,
    input  logic        i_dren,
    input  logic        i_dwen,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dwdata,
    output logic        o_dvd,
    output logic [31:0] o_drdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_vd,
    output logic        o_timeout
);

    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [15:0]   tcnt;
    logic          dreq;
    logic          streak_full;
    logic          grant_d;
    logic          grant_i;
    logic          busy;
    logic          tmo_hit;
    logic          done;

    assign dreq        = i_dren | i_dwen;
    assign streak_full = (32'(streak) >= MAX_DSTREAK);
    assign grant_d     = dreq && (!i_ireq || !streak_full);
    assign grant_i     = i_ireq && !grant_d;

    // tcnt counts completed busy cycles, so the current cycle is busy cycle tcnt+1
    assign busy    = (state != IDLE);
    assign tmo_hit = (TIMEOUT != 0) && ((32'(tcnt) + 32'd1) == TIMEOUT);
    assign done    = busy && (i_bus_vd || tmo_hit);

    assign o_ivd    = (state == IBUSY) && done;
    assign o_dvd    = (state == DBUSY) && done;
    assign o_idata  = (o_ivd && i_bus_vd) ? i_bus_rdata : 32'h0;
    assign o_drdata = (o_dvd && i_bus_vd) ? i_bus_rdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            tcnt        <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 32'h0;
            o_bus_wdata <= 32'h0;
            o_timeout   <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= DBUSY;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_dwen;
                        o_bus_addr  <= i_daddr;
                        o_bus_wdata <= i_dwdata;
                    end else if (grant_i) begin
                        state       <= IBUSY;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= i_iaddr;
                        o_bus_wdata <= 32'h0;
                    end
                    // a data grant with i_ireq high implies the streak was below the cap
                    if (!i_ireq)
                        streak <= '0;
                    else if (grant_d)
                        streak <= streak + SW'(1);
                    else
                        streak <= '0;
                end
                IBUSY, DBUSY: begin
                    if (done) begin
                        state     <= IDLE;
                        o_bus_req <= 1'b0;
                        tcnt      <= '0;
                        o_timeout <= !i_bus_vd;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_bus_req <= 1'b0;
                    tcnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized phase against a transaction-level model
// of the arbiter's rules (priority, starvation cap, latency and timeout).
module tb_mem_port_arbiter;

    localparam int MAXD = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ireq;
    logic [31:0] i_iaddr;
    logic        o_ivd;
    logic [31:0] o_idata;
    logic        i_dren;
    logic        i_dwen;
    logic [31:0] i_daddr;
    logic [31:0] i_dwdata;
    logic        o_dvd;
    logic [31:0] o_drdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata;
    logic        i_bus_vd;
    logic        o_timeout;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_ivd(o_ivd), .o_idata(o_idata),
        .i_dren(i_dren), .i_dwen(i_dwen), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
        .o_dvd(o_dvd), .o_drdata(o_drdata),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .i_bus_rdata(i_bus_rdata), .i_bus_vd(i_bus_vd),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One arbitration (IDLE) cycle: drive the core side, then check nothing is in flight.
    task automatic idle(input logic ireq, input logic [31:0] iaddr, input logic dren,
                        input logic dwen, input logic [31:0] daddr, input logic [31:0] dwdata,
                        input logic bus_vd, input logic exp_to);
        @(negedge clk);
        i_ireq = ireq; i_iaddr = iaddr; i_dren = dren; i_dwen = dwen;
        i_daddr = daddr; i_dwdata = dwdata; i_bus_vd = bus_vd; i_bus_rdata = $urandom;
        #1;
        chk("idle_bus_req", o_bus_req, 1'b0);
        chk("idle_ivd", o_ivd, 1'b0);
        chk("idle_dvd", o_dvd, 1'b0);
        chk("idle_idata", o_idata, 32'h0);
        chk("idle_drdata", o_drdata, 32'h0);
        chk("idle_timeout", o_timeout, exp_to);
    endtask

    // Busy phase of a granted transaction; the bus answers on busy cycle lat (0 = never).
    // Core-side inputs are scrambled throughout to show they are ignored.
    task automatic busy_phase(input logic is_instr, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                              output logic timed_out);
        logic fin;
        logic [31:0] exp_data;
        fin = 1'b0;
        timed_out = 1'b0;
        for (int k = 1; k <= TMO && !fin; k++) begin
            @(negedge clk);
            i_bus_vd = (k == lat);
            i_bus_rdata = (k == lat) ? rdata : $urandom;
            i_ireq = 1'($urandom); i_dren = 1'($urandom); i_dwen = 1'($urandom);
            i_iaddr = $urandom; i_daddr = $urandom; i_dwdata = $urandom;
            #1;
            fin = (k == lat) || (k == TMO);
            timed_out = fin && (k != lat);
            exp_data = (fin && !timed_out) ? rdata : 32'h0;
            chk("busy_bus_req", o_bus_req, 1'b1);
            chk("busy_addr", o_bus_addr, addr);
            chk("busy_we", o_bus_we, we);
            chk("busy_wdata", o_bus_wdata, wdata);
            chk("busy_timeout", o_timeout, 1'b0);
            chk("ivd", o_ivd, fin && is_instr);
            chk("dvd", o_dvd, fin && !is_instr);
            chk("idata", o_idata, is_instr ? exp_data : 32'h0);
            chk("drdata", o_drdata, is_instr ? 32'h0 : exp_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic to;
        logic ipend, dpend;
        logic [1:0] dk;
        logic [31:0] ia, da, dw;
        int streak_m;
        int lat;

        rst = 1'b1;
        i_ireq = 0; i_iaddr = 0; i_dren = 0; i_dwen = 0; i_daddr = 0; i_dwdata = 0;
        i_bus_rdata = 0; i_bus_vd = 0;
        @(negedge clk);
        #1;
        chk("rst_bus_req", o_bus_req, 1'b0);
        chk("rst_we", o_bus_we, 1'b0);
        chk("rst_addr", o_bus_addr, 32'h0);
        chk("rst_wdata", o_bus_wdata, 32'h0);
        chk("rst_timeout", o_timeout, 1'b0);
        chk("rst_ivd", o_ivd, 1'b0);
        chk("rst_dvd", o_dvd, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // single instruction read, answered three cycles after the bus request appears
        idle(1, 32'h100, 0, 0, 0, 0, 0, 0);
        busy_phase(1, 32'h100, 0, 0, 4, 32'h00500093, to);
        idle(0, 0, 0, 0, 0, 0, 0, to);

        // simultaneous requests: data first, instruction in the following IDLE cycle
        idle(1, 32'h104, 1, 0, 32'h2000, 0, 0, 0);
        busy_phase(0, 32'h2000, 0, 0, 2, 32'hA5A5_0001, to);
        idle(1, 32'h104, 0, 0, 0, 0, 0, to);
        busy_phase(1, 32'h104, 0, 0, 1, 32'h0000_0013, to);
        idle(0, 0, 0, 0, 0, 0, 0, to);

        // starvation cap: four data grants, then the waiting instruction
        for (int n = 0; n < MAXD; n++) begin
            idle(1, 32'h200, 1, 0, 32'h3000 + 32'(4 * n), 0, 0, n == 0 ? 1'b0 : to);
            busy_phase(0, 32'h3000 + 32'(4 * n), 0, 0, 1 + n, 32'h1000 + 32'(n), to);
        end
        idle(1, 32'h200, 1, 0, 32'h3100, 0, 0, to);
        busy_phase(1, 32'h200, 0, 0, 2, 32'h0010_0073, to);
        // streak is cleared again: a fresh instruction request loses to data
        idle(1, 32'h204, 1, 0, 32'h3100, 0, 0, to);
        busy_phase(0, 32'h3100, 0, 0, 1, 32'h2222_3333, to);
        idle(0, 0, 0, 0, 0, 0, 0, to);

        // writes, including read+write together treated as a write
        idle(0, 0, 0, 1, 32'h3004, 32'hDEADBEEF, 0, 0);
        busy_phase(0, 32'h3004, 1, 32'hDEADBEEF, 3, 32'h0, to);
        idle(0, 0, 1, 1, 32'h3008, 32'h1234_5678, 0, to);
        busy_phase(0, 32'h3008, 1, 32'h1234_5678, 2, 32'h0, to);
        idle(0, 0, 0, 0, 0, 0, 0, to);

        // timeout: no response, then a response exactly on the last busy cycle
        idle(0, 0, 1, 0, 32'h5000, 0, 0, 0);
        busy_phase(0, 32'h5000, 0, 0, 0, 32'h0, to);
        chk("timeout_taken", to, 1'b1);
        idle(0, 0, 0, 0, 0, 0, 1, 1'b1);
        idle(0, 0, 1, 0, 32'h5004, 0, 1, 1'b0);
        busy_phase(0, 32'h5004, 0, 0, TMO, 32'h7777_8888, to);
        chk("late_vd_wins", to, 1'b0);
        idle(0, 0, 0, 0, 0, 0, 0, 1'b0);

        // reset mid-transaction, late response must be discarded
        idle(0, 0, 1, 0, 32'h4000, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("pre_rst_bus_req", o_bus_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_bus_req", o_bus_req, 1'b0);
        chk("async_rst_addr", o_bus_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        i_dren = 1'b0;
        idle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic against the rule-level model
        ipend = 0; dpend = 0; dk = 0; ia = 0; da = 0; dw = 0;
        streak_m = 0; to = 0;
        repeat (300) begin
            if (!ipend && $urandom_range(0, 2) != 0) begin
                ipend = 1; ia = $urandom;
            end
            if (!dpend && $urandom_range(0, 2) != 0) begin
                dpend = 1; dk = 2'($urandom_range(1, 3)); da = $urandom; dw = $urandom;
            end
            idle(ipend, ia, dpend && dk[0], dpend && dk[1], da, dw, 1'($urandom), to);
            to = 0;
            lat = $urandom_range(0, 10);
            if (dpend && (!ipend || streak_m < MAXD)) begin
                streak_m = ipend ? streak_m + 1 : 0;
                busy_phase(0, da, dk[1], dw, lat, $urandom, to);
                dpend = 0;
            end else if (ipend) begin
                streak_m = 0;
                busy_phase(1, ia, 0, 0, lat, $urandom, to);
                ipend = 0;
            end else begin
                streak_m = 0;
            end
        end
        idle(0, 0, 0, 0, 0, 0, 0, to);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
